// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, stage-1 decode, stage-2 aligned pins.
// Define VGA_TEST_PATTERN_EN to replace rgb_in with eight vertical colour bars.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int CNT_W    = 11,
   parameter int COLOR_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic [3*COLOR_W-1:0]   rgb_in,
   output logic [CNT_W-1:0]       pixel_x,
   output logic [CNT_W-1:0]       pixel_y,
   output logic                   de,
   output logic                   line_start,
   output logic                   frame_start,
   output logic [COLOR_W-1:0]     red,
   output logic [COLOR_W-1:0]     green,
   output logic [COLOR_W-1:0]     blue,
   output logic                   h_sync,
   output logic                   v_sync,
   output logic                   blank_n,
   output logic                   sync_n
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic             HS_ON    = (H_POL != 0);
   localparam logic             VS_ON    = (V_POL != 0);

   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             hs_s1, vs_s1;
   logic             hs_raw, vs_raw, de_raw;
   logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign de_raw = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
   assign hs_raw = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_ON : ~HS_ON;
   assign vs_raw = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_ON : ~VS_ON;

   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_x     <= '0;
         pixel_y     <= '0;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         hs_s1       <= ~HS_ON;
         vs_s1       <= ~VS_ON;
      end else if (en) begin
         pixel_x     <= h_cnt;
         pixel_y     <= v_cnt;
         de          <= de_raw;
         line_start  <= (h_cnt == '0);
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
         hs_s1       <= hs_raw;
         vs_s1       <= vs_raw;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   // Bar codes are {r,g,b}: white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(H_ACTIVE / 8);
   localparam logic [2:0] BAR_CODE [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                           3'b101, 3'b100, 3'b001, 3'b000};
   logic [CNT_W-1:0] bar_idx;
   logic [2:0]       bar_code;

   always_comb begin
      bar_idx  = pixel_x / BAR_W_C;
      bar_code = 3'b000;
      if (bar_idx < CNT_W'(8)) bar_code = BAR_CODE[bar_idx[2:0]];
      pix_r = {COLOR_W{bar_code[2]}};
      pix_g = {COLOR_W{bar_code[1]}};
      pix_b = {COLOR_W{bar_code[0]}};
   end
`else
   always_comb begin
      pix_r = rgb_in[3*COLOR_W-1:2*COLOR_W];
      pix_g = rgb_in[2*COLOR_W-1:COLOR_W];
      pix_b = rgb_in[COLOR_W-1:0];
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         red     <= '0;
         green   <= '0;
         blue    <= '0;
         h_sync  <= ~HS_ON;
         v_sync  <= ~VS_ON;
         blank_n <= 1'b0;
      end else if (en) begin
         red     <= de ? pix_r : '0;
         green   <= de ? pix_g : '0;
         blue    <= de ? pix_b : '0;
         h_sync  <= hs_s1;
         v_sync  <= vs_s1;
         blank_n <= de;
      end
   end

   assign sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default horizontal timing, short 8-line frame.
// Honours VGA_TEST_PATTERN_EN so the same bench checks either colour source.
module tb_vga_timing_gen;

   localparam int HT = 800;
   localparam int VT = 8;

   logic        clk = 1'b0;
   logic        reset, en;
   logic [23:0] rgb_in;
   logic [10:0] pixel_x, pixel_y;
   logic        de, line_start, frame_start;
   logic [7:0]  red, green, blue;
   logic        h_sync, v_sync, blank_n, sync_n;
   logic [52:0] obs, prev_obs;

   int n_pass = 0;
   int n_total = 0;
   int k = 0;

   vga_timing_gen #(
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .rgb_in(rgb_in),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .de(de),
      .line_start(line_start), .frame_start(frame_start),
      .red(red), .green(green), .blue(blue),
      .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n), .sync_n(sync_n)
   );

   always #5 clk = ~clk;

   assign rgb_in = {pixel_x[7:0] ^ 8'h3C, pixel_y[7:0], 8'h5A};
   assign obs = {pixel_x, pixel_y, de, line_start, frame_start,
                 red, green, blue, h_sync, v_sync, blank_n, sync_n};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      assert (got === want) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
   endtask

   // Expected outputs after kk enabled edges since reset release.
   function automatic logic [52:0] exp_vec(input int kk);
      logic [10:0] x1, y1;
      logic        de1, ls1, fs1, hs2, vs2, bn2;
      logic [7:0]  r, g, b;
      int          n, m, xm, ym, bar;
      logic [2:0]  code;
      x1 = '0; y1 = '0; de1 = 0; ls1 = 0; fs1 = 0;
      r = '0; g = '0; b = '0; hs2 = 1; vs2 = 1; bn2 = 0;
      if (kk >= 1) begin
         n   = kk - 1;
         x1  = 11'(n % HT);
         y1  = 11'((n / HT) % VT);
         de1 = (x1 < 640) && (y1 < 4);
         ls1 = (x1 == 0);
         fs1 = (x1 == 0) && (y1 == 0);
      end
      if (kk >= 2) begin
         m   = kk - 2;
         xm  = m % HT;
         ym  = (m / HT) % VT;
         bn2 = (xm < 640) && (ym < 4);
         hs2 = !((xm >= 656) && (xm < 752));
         vs2 = !((ym >= 5) && (ym < 7));
         if (bn2) begin
`ifdef VGA_TEST_PATTERN_EN
            bar  = xm / 80;
            code = (bar == 0) ? 3'b111 : (bar == 1) ? 3'b110 : (bar == 2) ? 3'b011 :
                   (bar == 3) ? 3'b010 : (bar == 4) ? 3'b101 : (bar == 5) ? 3'b100 :
                   (bar == 6) ? 3'b001 : 3'b000;
            r = {8{code[2]}}; g = {8{code[1]}}; b = {8{code[0]}};
`else
            bar = 0; code = 3'b000;
            r = 8'(xm) ^ 8'h3C; g = 8'(ym); b = 8'h5A;
`endif
         end
      end
      return {x1, y1, de1, ls1, fs1, r, g, b, hs2, vs2, bn2, 1'b0};
   endfunction

   task automatic step(input logic e);
      en = e;
      @(posedge clk);
      #1;
      if (e) k++;
   endtask

   initial begin
      int hs_low, vs_low, de_cnt, hs_line0, fs_cnt, fs_last, fs_period;
      int hs_first_x, ls_rise0, ls_rise1;
      bit hs_seen, hit, prev_ls;
      hs_low = 0; vs_low = 0; de_cnt = 0; hs_line0 = 0; fs_cnt = 0;
      fs_last = -1; fs_period = 0; hs_first_x = -1; hs_seen = 0;
      ls_rise0 = -1; ls_rise1 = -1; hit = 0; prev_ls = 0;

      reset = 1'b1;
      en    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_vec", obs, exp_vec(0));
      check("rst_h_sync", h_sync, 1'b1);
      check("rst_v_sync", v_sync, 1'b1);
      check("rst_sync_n", sync_n, 1'b0);

      reset = 1'b0;
      k = 0;
      for (int i = 0; i < 7200; i++) begin
         step(1'b1);
         check("run_vec", obs, exp_vec(k));
         if (k == 1) begin
            check("c1_pixel_x", pixel_x, 11'd0);
            check("c1_de", de, 1'b1);
            check("c1_frame_start", frame_start, 1'b1);
            check("c1_line_start", line_start, 1'b1);
         end
         if (k == 2) begin
            check("c2_blank_n", blank_n, 1'b1);
`ifndef VGA_TEST_PATTERN_EN
            check("c2_red", red, 8'h3C);
            check("c2_blue", blue, 8'h5A);
`else
            check("c2_red", red, 8'hFF);
`endif
         end
         if (k >= 2 && k <= 6401) begin
            if (!h_sync) hs_low++;
            if (!v_sync) vs_low++;
            if (blank_n) de_cnt++;
            if (!h_sync && !hs_seen) begin
               hs_seen    = 1;
               hs_first_x = int'(pixel_x);
            end
         end
         if (k >= 2 && k <= HT + 1 && !h_sync) hs_line0++;
         if (frame_start) begin
            if (k <= 6400) fs_cnt++;
            if (fs_last >= 0 && fs_period == 0) fs_period = k - fs_last;
            fs_last = k;
         end
      end
      check("hs_low_line0", hs_line0, 96);
      check("hs_first_x", hs_first_x, 657);
      check("hs_low_frame", hs_low, 768);
      check("vs_low_frame", vs_low, 1600);
      check("de_cnt_frame", de_cnt, 2560);
      check("fs_per_frame", fs_cnt, 1);
      check("fs_period", fs_period, 6400);

      // en toggled 1,0,1,0: every other clock advances, frozen otherwise.
      for (int i = 0; i < 3400; i++) begin
         prev_obs = obs;
         step((i % 2) == 0);
         check("tog_vec", obs, exp_vec(k));
         if ((i % 2) == 1) check("tog_freeze", obs, prev_obs);
         if (line_start && !prev_ls) begin
            if (ls_rise0 < 0) ls_rise0 = i;
            else if (ls_rise1 < 0) ls_rise1 = i;
         end
         prev_ls = line_start;
      end
      check("tog_line_period", ls_rise1 - ls_rise0, HT * 2);

      for (int i = 0; i < 8000 && !hit; i++) begin
         step(1'b1);
         if (pixel_x == 11'd300 && pixel_y == 11'd2) hit = 1;
      end
      check("reach_300_2", hit, 1'b1);
      check("pre_rst_de", de, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_vec", obs, exp_vec(0));
      reset = 1'b0;
      k = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1);
         check("restart_vec", obs, exp_vec(k));
      end
      check("restart_x", pixel_x, 11'd4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
